mykey_in: RTL and testbench

Avalon-MM slave peripheral that debounces the four DE1-SoC push buttons (KEY[3:0]) and reports their state, press edges and a press count to the Nios II. It sits in the Qsys system upstream of the CPU as the input counterpart of the 7-segment PIO: it converts raw board pins into clean register state and a level interrupt.

---
 rtl/mykey_in_pkg.sv | 36 +++
 rtl/mykey_in_debounce.sv | 62 ++++++
 rtl/mykey_in.sv | 133 +++++++++++++
 tb/tb_mykey_in.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mykey_in_pkg.sv
// mykey_in_pkg: shared constants and helpers for the push-button peripheral.
// Optional feature macro: MYKEY_IN_RELEASE_EDGE_EN (adds release-edge capture).
package mykey_in_pkg;

  localparam int NKEY = 4;

  // Events produced per key: press only, or press + release.
`ifdef MYKEY_IN_RELEASE_EDGE_EN
  localparam int EVT_W = 2;
`else
  localparam int EVT_W = 1;
`endif

  // EDGE/MASK register width: press bits [3:0], release bits [7:4] if enabled.
  localparam int EDGE_W = NKEY * EVT_W;

  // Avalon word addresses of the register file.
  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_EDGE  = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  // Width able to hold a popcount of all keys (0..NKEY).
  localparam int POP_W = $clog2(NKEY + 1);

  // Number of set bits in a per-key event vector.
  function automatic logic [POP_W-1:0] popcount(input logic [NKEY-1:0] v);
    logic [POP_W-1:0] s;
    s = '0;
    for (int i = 0; i < NKEY; i++) begin
      s = s + POP_W'(v[i]);
    end
    return s;
  endfunction

endpackage

// File: rtl/mykey_in_debounce.sv
// mykey_in_debounce: one key channel. Two-flop synchronizer, inversion to
// positive logic, stability counter and the accepted `stable` level.
// evt[0] pulses on the cycle `stable` rises; evt[1] (only with
// MYKEY_IN_RELEASE_EDGE_EN) pulses on the cycle it falls. The pulses are
// combinational so the register file updates on the same edge as `stable`.
module mykey_in_debounce
  import mykey_in_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             key_n,
  output logic             stable,
  output logic [EVT_W-1:0] evt
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          stable_reg;
  logic          pressed;
  logic          differ;
  logic          accept;

  assign pressed = ~sync_reg[1];
  assign differ  = (pressed != stable_reg);
  assign accept  = differ && (cnt_reg == CNT_MAX);

  // Synchronizer resets to the idle-high level so a held key is not seen at reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], key_n};
    end
  end

  // Count consecutive cycles of disagreement; accept the new level after DB_CYCLES.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else if (!differ) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg    <= '0;
      stable_reg <= pressed;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign stable = stable_reg;
  assign evt[0] = accept & pressed;
`ifdef MYKEY_IN_RELEASE_EDGE_EN
  assign evt[1] = accept & ~pressed;
`endif

endmodule

// File: rtl/mykey_in.sv
// mykey_in: Avalon-MM slave reporting debounced KEY[3:0] state, sticky press
// edges, a press counter and a masked level interrupt to the Nios II.
// Optional feature macro: MYKEY_IN_RELEASE_EDGE_EN (EDGE/MASK bits [7:4]
// track key releases).
module mykey_in
  import mykey_in_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  KEY_N,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  logic [NKEY-1:0]   stable_vec;
  logic [NKEY-1:0]   press_vec;
  logic [EVT_W-1:0]  evt_w [NKEY];
  logic [EDGE_W-1:0] edge_set;

  logic [EDGE_W-1:0] mask_reg;
  logic [EDGE_W-1:0] edge_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              irq_reg;
  logic [31:0]       readdata_reg;
  logic [31:0]       rd_mux;

  logic wr_mask;
  logic wr_edge;
  logic wr_count;

  // Only the low EDGE_W bits of writedata carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:EDGE_W];

  genvar gi;
  generate
    for (gi = 0; gi < NKEY; gi++) begin : g_key
      mykey_in_debounce #(
        .DB_CYCLES (DB_CYCLES)
      ) u_debounce (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .key_n  (KEY_N[gi]),
        .stable (stable_vec[gi]),
        .evt    (evt_w[gi])
      );
      assign press_vec[gi] = evt_w[gi][0];
    end
  endgenerate

`ifdef MYKEY_IN_RELEASE_EDGE_EN
  logic [NKEY-1:0] release_vec;
  generate
    for (gi = 0; gi < NKEY; gi++) begin : g_rel
      assign release_vec[gi] = evt_w[gi][1];
    end
  endgenerate
  assign edge_set = {release_vec, press_vec};
`else
  assign edge_set = press_vec;
`endif

  assign wr_mask  = write && (address == ADDR_MASK);
  assign wr_edge  = write && (address == ADDR_EDGE);
  assign wr_count = write && (address == ADDR_COUNT);

  // Interrupt enable mask, plain read/write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mask_reg <= '0;
    end else if (wr_mask) begin
      mask_reg <= writedata[EDGE_W-1:0];
    end
  end

  // Sticky edges: write-1-to-clear, but a new event on the same bit wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      edge_reg <= '0;
    end else begin
      edge_reg <= (edge_reg & ~(wr_edge ? writedata[EDGE_W-1:0] : '0)) | edge_set;
    end
  end

  // Press counter: any write clears it, this cycle's presses are still added.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_reg <= '0;
    end else begin
      count_reg <= (wr_count ? '0 : count_reg) + CNT_W'(popcount(press_vec));
    end
  end

  // Level interrupt registered from the currently latched edges.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= |(edge_reg & mask_reg);
    end
  end

  // Read mux over pre-write register values.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:  rd_mux[NKEY-1:0]   = stable_vec;
      ADDR_MASK:  rd_mux[EDGE_W-1:0] = mask_reg;
      ADDR_EDGE:  rd_mux[EDGE_W-1:0] = edge_reg;
      ADDR_COUNT: rd_mux[CNT_W-1:0]  = count_reg;
    endcase
  end

  // Read data register: latency 1, holds its value when not reading.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      readdata_reg <= '0;
    end else if (read) begin
      readdata_reg <= rd_mux;
    end
  end

  assign readdata = readdata_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_mykey_in.sv
// tb_mykey_in: directed test of mykey_in with DB_CYCLES = 16.
module tb_mykey_in;
  import mykey_in_pkg::*;

`ifdef MYKEY_IN_RELEASE_EDGE_EN
  localparam logic [31:0] MASK_ALL = 32'hFF;
`else
  localparam logic [31:0] MASK_ALL = 32'hF;
`endif

  logic        CLK;
  logic        RST_N;
  logic [3:0]  KEY_N;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] d;

  mykey_in #(
    .DB_CYCLES (16),
    .CNT_W     (16)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .KEY_N     (KEY_N),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address   = a;
    writedata = v;
    write     = 1'b1;
    @(negedge CLK);
    write     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    read    = 1'b1;
    @(negedge CLK);
    read    = 1'b0;
    v       = readdata;
  endtask

  initial begin
    RST_N = 1'b0; KEY_N = 4'hF; address = '0;
    read = 1'b0; write = 1'b0; writedata = '0;
    tick(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    RST_N = 1'b1;
    tick(1);
    rd(ADDR_DATA, d);  check("rst_data", d, 32'h0);
    rd(ADDR_MASK, d);  check("rst_mask", d, 32'h0);
    rd(ADDR_EDGE, d);  check("rst_edge", d, 32'h0);
    rd(ADDR_COUNT, d); check("rst_count", d, 32'h0);

    // Key 0 held 30 clocks, DATA polled every cycle to pin acceptance at clock 18.
    KEY_N[0] = 1'b0; address = ADDR_DATA; read = 1'b1;
    tick(18); check("k0_data_before18", readdata, 32'h0);
    tick(1);  check("k0_data_at18", readdata, 32'h1);
    read = 1'b0;
    tick(11);
    check("k0_irq_masked", {31'b0, irq}, 32'h0);
    rd(ADDR_EDGE, d);  check("k0_edge", d & 32'hF, 32'h1);
    rd(ADDR_COUNT, d); check("k0_count", d, 32'h1);
    KEY_N = 4'hF; tick(20);
    rd(ADDR_DATA, d);  check("k0_release_data", d, 32'h0);
    wr(ADDR_EDGE, MASK_ALL);
    rd(ADDR_EDGE, d);  check("k0_edge_w1c", d, 32'h0);

    // Masked interrupt on key 0.
    wr(ADDR_MASK, 32'h1);
    rd(ADDR_MASK, d); check("mask_rw", d, 32'h1);
    KEY_N[0] = 1'b0;
    tick(18); check("irq_before", {31'b0, irq}, 32'h0);
    tick(1);  check("irq_set", {31'b0, irq}, 32'h1);
    wr(ADDR_EDGE, 32'h1);
    check("irq_hold_on_clear", {31'b0, irq}, 32'h1);
    tick(1);  check("irq_cleared", {31'b0, irq}, 32'h0);
    KEY_N = 4'hF; tick(20);
    wr(ADDR_EDGE, MASK_ALL);
    wr(ADDR_MASK, 32'h0);

    // Short glitches on key 2 must be rejected.
    wr(ADDR_COUNT, 32'h0);
    for (int i = 0; i < 4; i++) begin
      KEY_N[2] = 1'b0; tick(10);
      KEY_N[2] = 1'b1; tick(5);
    end
    tick(20);
    rd(ADDR_DATA, d);  check("glitch_data", d, 32'h0);
    rd(ADDR_EDGE, d);  check("glitch_edge", d, 32'h0);
    rd(ADDR_COUNT, d); check("glitch_count", d, 32'h0);

    // All four keys at once, then count clear racing a two-key press.
    KEY_N = 4'h0; tick(20);
    rd(ADDR_DATA, d);  check("all_data", d, 32'hF);
    rd(ADDR_EDGE, d);  check("all_edge", d & 32'hF, 32'hF);
    rd(ADDR_COUNT, d); check("all_count", d, 32'h4);
    KEY_N = 4'hF; tick(20);
    wr(ADDR_EDGE, MASK_ALL);
    KEY_N = 4'b1100; tick(17);
    wr(ADDR_COUNT, 32'h0);
    rd(ADDR_COUNT, d); check("clear_race_count", d, 32'h2);
    rd(ADDR_EDGE, d);  check("pair_edge", d & 32'hF, 32'h3);

    // W1C on EDGE[1] in the same cycle key 1 is accepted again: set wins.
    KEY_N = 4'hF; tick(20);
    KEY_N = 4'b1101; tick(17);
    wr(ADDR_EDGE, 32'h2);
    rd(ADDR_EDGE, d);  check("w1c_race_edge", d & 32'hF, 32'h3);
    wr(ADDR_EDGE, 32'h1);
    rd(ADDR_EDGE, d);  check("w1c_bit0_only", d & 32'hF, 32'h2);
    rd(ADDR_COUNT, d); check("w1c_race_count", d, 32'h3);

    // RO write ignored, read+write same cycle returns old value, mask width.
    wr(ADDR_DATA, 32'hF);
    rd(ADDR_DATA, d);  check("data_ro", d, 32'h2);
    wr(ADDR_MASK, 32'h5);
    address = ADDR_MASK; writedata = 32'hA; read = 1'b1; write = 1'b1;
    tick(1);
    read = 1'b0; write = 1'b0;
    check("rw_same_cycle_old", readdata, 32'h5);
    rd(ADDR_MASK, d);  check("rw_same_cycle_new", d, 32'hA);
    wr(ADDR_MASK, 32'hFFFF_FFFF);
    rd(ADDR_MASK, d);  check("mask_width", d, MASK_ALL);
    tick(2);
    check("irq_before_reset", {31'b0, irq}, 32'h1);

    // Reset during a debounce with key 1 held through it.
    KEY_N = 4'hF; tick(20);
    KEY_N[1] = 1'b0; tick(8);
    RST_N = 1'b0; address = ADDR_DATA; read = 1'b1;
    tick(3);
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    RST_N = 1'b1;
    tick(18); check("midrst_data_before18", readdata, 32'h0);
    tick(1);  check("midrst_data_at18", readdata, 32'h2);
    read = 1'b0;
    rd(ADDR_COUNT, d); check("midrst_count", d, 32'h1);
    rd(ADDR_MASK, d);  check("midrst_mask", d, 32'h0);
    KEY_N = 4'hF;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
